// File: rtl/frame_uploader_pkg.sv
// Shared frame-stream types: FSM states and in-band marker words.
// Used by both the uploader and the downloader side of the frame path.
package FrameUploaderTypes;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_FRAME,
        WAIT_ROW,
        FILL,
        WRITE_REQ,
        WRITE_BURST,
        ROW_END,
        DONE,
        ERROR
    } t_state;

    localparam logic [16:0] MARK_FRAME_START = 17'h10000;
    localparam logic [16:0] MARK_ROW_START   = 17'h10001;
    localparam logic [16:0] MARK_FRAME_END   = 17'h1FFFF;

endpackage

// File: rtl/frame_uploader_pixel_pack_cache.sv
// Burst staging cache: pixel-wide write port, pixel-pair read port.
// Read data is registered and only refreshed while re is high.
module pixel_pack_cache #(
    parameter int CACHE_SIZE = 16,
    parameter int AW = $clog2(CACHE_SIZE),
    parameter int RW = $clog2(CACHE_SIZE / 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [RW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [15:0] mem_q [CACHE_SIZE];
    logic [31:0] rdata_q;

    // Pixel storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered pair read: earlier pixel in the low half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= {mem_q[{raddr, 1'b1}], mem_q[{raddr, 1'b0}]};
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_uploader.sv
// Frame uploader: parses a marker-delimited pixel FIFO stream and
// writes each row to PSRAM as fixed-size bursts of packed pixel pairs.
module frame_uploader
    import FrameUploaderTypes::*;
#(
    parameter int MEMORY_BURST = 32,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [20:0] base_addr,
    input  logic        queue_empty,
    input  logic [16:0] queue_data_i,
    output logic        rd_en,
    output logic        write_rq,
    input  logic        write_ack,
    output logic [20:0] write_addr,
    output logic [31:0] write_data,
    output logic        mem_wr_en,
    output logic        upload_done,
    output logic        frame_error
);

    localparam int CACHE_SIZE = MEMORY_BURST / 2;
    localparam int WORDS      = CACHE_SIZE / 2;
    localparam int CW         = $clog2(CACHE_SIZE);
    localparam int BW         = $clog2(WORDS);
    localparam int COLW       = $clog2(FRAME_WIDTH + 1);
    localparam int ROWW       = $clog2(FRAME_HEIGHT + 1);

    t_state          state_q;
    logic            pend_q;
    logic [ROWW-1:0] row_q;
    logic [COLW-1:0] col_q;
    logic [CW-1:0]   cache_cnt_q;
    logic [BW-1:0]   burst_cnt_q;
    logic [20:0]     write_addr_q;
    logic            write_rq_q;
    logic            mem_wr_en_q;
    logic            upload_done_q;
    logic            frame_error_q;

    logic            pop_state;
    logic            is_marker;
    logic            cache_we;
    logic            cache_re;
    logic [BW-1:0]   cache_raddr;

    // One pop in flight at a time: the word is consumed the cycle
    // after rd_en, so nothing is ever popped past a state change.
    always_comb begin
        pop_state = (state_q == WAIT_FRAME) ||
                    (state_q == WAIT_ROW) ||
                    (state_q == FILL);
        rd_en     = pop_state && !queue_empty && !pend_q;
        is_marker = queue_data_i[16];
    end

    // Cache ports: prefetch word 0 while waiting for the grant, then
    // stay one word ahead so each burst cycle has its data ready.
    always_comb begin
        cache_we    = (state_q == FILL) && pend_q && !is_marker;
        cache_re    = (state_q == WRITE_REQ) || (state_q == WRITE_BURST);
        cache_raddr = (state_q == WRITE_BURST) ? burst_cnt_q + BW'(1)
                                               : '0;
    end

    pixel_pack_cache #(
        .CACHE_SIZE (CACHE_SIZE)
    ) u_cache (
        .clk   (clk),
        .reset (reset),
        .we    (cache_we),
        .waddr (cache_cnt_q),
        .wdata (queue_data_i[15:0]),
        .re    (cache_re),
        .raddr (cache_raddr),
        .rdata (write_data)
    );

    // Main control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pend_q        <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            cache_cnt_q   <= '0;
            burst_cnt_q   <= '0;
            write_addr_q  <= '0;
            write_rq_q    <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            upload_done_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            pend_q        <= rd_en;
            upload_done_q <= 1'b0;
            frame_error_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    write_addr_q <= base_addr;
                    if (start) begin
                        row_q   <= '0;
                        state_q <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (pend_q && queue_data_i == MARK_FRAME_START) begin
                        state_q <= WAIT_ROW;
                    end
                end
                WAIT_ROW: begin
                    if (pend_q) begin
                        if (queue_data_i == MARK_ROW_START) begin
                            col_q       <= '0;
                            cache_cnt_q <= '0;
                            state_q     <= FILL;
                        end else if (queue_data_i == MARK_FRAME_END &&
                                     row_q == ROWW'(FRAME_HEIGHT)) begin
                            upload_done_q <= 1'b1;
                            state_q       <= DONE;
                        end else begin
                            frame_error_q <= 1'b1;
                            state_q       <= ERROR;
                        end
                    end
                end
                FILL: begin
                    if (pend_q) begin
                        if (is_marker) begin
                            frame_error_q <= 1'b1;
                            state_q       <= ERROR;
                        end else begin
                            col_q       <= col_q + COLW'(1);
                            cache_cnt_q <= cache_cnt_q + CW'(1);
                            if (cache_cnt_q == CW'(CACHE_SIZE - 1)) begin
                                write_rq_q <= 1'b1;
                                state_q    <= WRITE_REQ;
                            end
                        end
                    end
                end
                WRITE_REQ: begin
                    if (write_ack) begin
                        burst_cnt_q <= '0;
                        mem_wr_en_q <= 1'b1;
                        state_q     <= WRITE_BURST;
                    end
                end
                WRITE_BURST: begin
                    burst_cnt_q <= burst_cnt_q + BW'(1);
                    if (burst_cnt_q == BW'(WORDS - 2)) begin
                        write_rq_q <= 1'b0;
                    end
                    if (burst_cnt_q == BW'(WORDS - 1)) begin
                        mem_wr_en_q  <= 1'b0;
                        write_addr_q <= write_addr_q + 21'(CACHE_SIZE);
                        state_q      <= (col_q == COLW'(FRAME_WIDTH))
                                        ? ROW_END : FILL;
                    end
                end
                ROW_END: begin
                    row_q   <= row_q + ROWW'(1);
                    state_q <= WAIT_ROW;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                ERROR: begin
                    write_addr_q <= base_addr;
                    state_q      <= WAIT_FRAME;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign write_rq    = write_rq_q;
    assign write_addr  = write_addr_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign upload_done = upload_done_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_frame_uploader.sv
// Bench for frame_uploader on a 32x2 frame: FIFO and PSRAM models,
// burst scoreboard, scenario table and an async-reset-mid-burst case.
module tb_frame_uploader;

    typedef struct packed {
        logic [20:0] addr;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic [20:0] base;
        logic [15:0] pix0;
        int          ack;
        bit          gap;
        bit          err;
        bit          smid;
        int          exp_bursts;
        int          exp_done;
        int          exp_err;
    } scen_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [20:0] base_addr;
    logic        queue_empty;
    logic [16:0] queue_data_i;
    logic        rd_en;
    logic        write_rq;
    logic        write_ack;
    logic [20:0] write_addr;
    logic [31:0] write_data;
    logic        mem_wr_en;
    logic        upload_done;
    logic        frame_error;

    frame_uploader #(
        .MEMORY_BURST (32),
        .FRAME_WIDTH  (32),
        .FRAME_HEIGHT (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .queue_empty  (queue_empty),
        .queue_data_i (queue_data_i),
        .rd_en        (rd_en),
        .write_rq     (write_rq),
        .write_ack    (write_ack),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .mem_wr_en    (mem_wr_en),
        .upload_done  (upload_done),
        .frame_error  (frame_error)
    );

    int checks = 0;
    int failures = 0;
    int n_rq, n_done, n_err, viol, run_len, rq_cnt, ack_dly;
    bit gap, tog, prev_rq;
    logic [16:0] src [$];
    word_t exp_q [$];
    scen_t tbl [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Source FIFO: popped word appears on queue_data_i next cycle.
    always @(posedge clk) begin
        if (rd_en && src.size() > 0) begin
            queue_data_i <= src.pop_front();
        end
    end

    // Monitor, scoreboard and PSRAM grant model.
    always @(negedge clk) begin
        if (reset) begin
            run_len   = 0;
            rq_cnt    = 0;
            write_ack = 1'b0;
            prev_rq   = 1'b0;
        end else begin
            if (rd_en && queue_empty) viol++;
            if (rd_en && (write_rq || mem_wr_en)) viol++;
            if (mem_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(write_data), 64'hDEAD);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("burst_data", 64'(write_data), 64'(w.data));
                    chk("burst_addr", 64'(write_addr), 64'(w.addr));
                end
                run_len++;
            end else if (run_len != 0) begin
                chk("burst_len", 64'(run_len), 64'd8);
                run_len = 0;
            end
            if (write_rq && !prev_rq) n_rq++;
            prev_rq = write_rq;
            if (upload_done) n_done++;
            if (frame_error) n_err++;
            if (write_rq && !mem_wr_en) begin
                rq_cnt++;
                write_ack = (rq_cnt == ack_dly);
            end else begin
                rq_cnt    = 0;
                write_ack = 1'b0;
            end
        end
        tog = ~tog;
        queue_empty = (src.size() == 0) || (gap && tog);
    end

    task automatic push_frame(input logic [20:0] base,
                              input logic [15:0] pix0);
        logic [15:0] p0, p1;
        word_t w;
        src.push_back(17'h10000);
        for (int r = 0; r < 2; r++) begin
            src.push_back(17'h10001);
            for (int c = 0; c < 32; c++) begin
                p0 = pix0 + 16'(r * 32 + c);
                src.push_back({1'b0, p0});
            end
        end
        src.push_back(17'h1FFFF);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                p0 = pix0 + 16'(b * 16 + 2 * k);
                p1 = pix0 + 16'(b * 16 + 2 * k + 1);
                w.addr = base + 21'(16 * b);
                w.data = {p1, p0};
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic run_scenario(input int id, input scen_t s);
        string tag;
        tag = $sformatf("s%0d_", id);
        n_rq = 0;
        n_done = 0;
        n_err = 0;
        viol = 0;
        ack_dly = s.ack;
        gap = s.gap;
        base_addr = s.base;
        if (s.err) begin
            src.push_back(17'h10000);
            src.push_back(17'h10001);
            for (int i = 0; i < 5; i++) src.push_back(17'(i + 16'h0700));
            src.push_back(17'h10001);
        end
        push_frame(s.base, s.pix0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 6000 && n_done == 0; c++) begin
            @(negedge clk);
            start = s.smid && (c == 60);
        end
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk({tag, "bursts"}, 64'(n_rq), 64'(s.exp_bursts));
        chk({tag, "done"}, 64'(n_done), 64'(s.exp_done));
        chk({tag, "err"}, 64'(n_err), 64'(s.exp_err));
        chk({tag, "exp_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "src_left"}, 64'(src.size()), 64'd0);
        chk({tag, "rd_viol"}, 64'(viol), 64'd0);
        exp_q.delete();
        src.delete();
        gap = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        chk({tag, "_write_rq"}, 64'(write_rq), 64'd0);
        chk({tag, "_mem_wr_en"}, 64'(mem_wr_en), 64'd0);
        chk({tag, "_done"}, 64'(upload_done), 64'd0);
        chk({tag, "_err"}, 64'(frame_error), 64'd0);
        chk({tag, "_wdata"}, 64'(write_data), 64'd0);
        chk({tag, "_waddr"}, 64'(write_addr), 64'd0);
    endtask

    initial begin
        int n;
        scen_t fresh;
        tbl[0] = '{21'h000100, 16'h0001, 1, 0, 0, 0, 4, 1, 0};
        tbl[1] = '{21'h1FFFE0, 16'h8000, 3, 0, 0, 1, 4, 1, 0};
        tbl[2] = '{21'h000200, 16'h0100, 20, 0, 0, 0, 4, 1, 0};
        tbl[3] = '{21'h000100, 16'h0001, 1, 1, 0, 0, 4, 1, 0};
        tbl[4] = '{21'h000300, 16'h4000, 2, 0, 1, 0, 4, 1, 1};

        reset = 1'b1;
        start = 1'b0;
        base_addr = 21'h0;
        queue_data_i = 17'h0;
        write_ack = 1'b0;
        queue_empty = 1'b1;
        gap = 1'b0;
        tog = 1'b0;
        ack_dly = 1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_scenario(i, tbl[i]);
        end

        base_addr = 21'h000100;
        ack_dly = 1;
        push_frame(21'h000100, 16'h0A00);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 3000 && n < 4; c++) begin
            @(negedge clk);
            if (mem_wr_en) n++;
        end
        chk("abort_reach_word4", 64'(n), 64'd4);
        #1 reset = 1'b1;
        #1 chk_idle_outputs("abort");
        exp_q.delete();
        src.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        fresh = '{21'h000140, 16'h0C00, 2, 0, 0, 0, 4, 1, 0};
        run_scenario(5, fresh);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
